// File: rtl/reorder_buffer.sv
// 15-entry circular reorder buffer: in-order retire, CDB writeback, operand lookup, mispredict flush.
// Optional ROB_CDB_BYPASS_EN: operand lookups also see same-cycle CDB broadcasts.
module reorder_buffer (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        alloc_valid,
  input  logic [1:0]  alloc_type,
  input  logic [4:0]  alloc_rd,
  input  logic        alloc_pred_taken,
  input  logic [31:0] alloc_alt_pc,
  output logic [3:0]  alloc_id,
  output logic        rob_full,
  input  logic [3:0]  cdb_alu_rob_id,
  input  logic [31:0] cdb_alu_value,
  input  logic [3:0]  cdb_mem_rob_id,
  input  logic [31:0] cdb_mem_value,
  input  logic [3:0]  query_j_id,
  input  logic [3:0]  query_k_id,
  output logic        query_j_ready,
  output logic [31:0] query_j_value,
  output logic        query_k_ready,
  output logic [31:0] query_k_value,
  output logic        commit_valid,
  output logic [3:0]  commit_rob_id,
  output logic [4:0]  commit_rd,
  output logic        commit_we,
  output logic [31:0] commit_value,
  output logic        commit_store,
  output logic        flush_out,
  output logic [31:0] flush_pc
);
  localparam logic [1:0] T_REG    = 2'b00;
  localparam logic [1:0] T_BRANCH = 2'b01;
  localparam logic [1:0] T_STORE  = 2'b10;

  // Entry 0 exists only so 4-bit IDs index directly; it is never allocated.
  logic [15:0] busy_q, busy_d, ready_q, ready_d, pred_q, pred_d;
  logic [1:0]  type_q  [16];
  logic [1:0]  type_d  [16];
  logic [4:0]  rd_q    [16];
  logic [4:0]  rd_d    [16];
  logic [31:0] value_q [16];
  logic [31:0] value_d [16];
  logic [31:0] alt_q   [16];
  logic [31:0] alt_d   [16];
  logic [3:0]  head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic        commit_valid_q, commit_valid_d, commit_we_q, commit_we_d;
  logic        commit_store_q, commit_store_d, flush_q, flush_d;
  logic [3:0]  commit_id_q, commit_id_d;
  logic [4:0]  commit_rd_q, commit_rd_d;
  logic [31:0] commit_value_q, commit_value_d, flush_pc_q, flush_pc_d;
  logic        alloc_fire, retire_fire, mispredict;

  function automatic logic [3:0] ptr_inc(input logic [3:0] p);
    return (p == 4'd15) ? 4'd1 : p + 4'd1;
  endfunction

  assign rob_full = (count_q == 4'd15);
  assign alloc_id = tail_q;

  always_comb begin
    alloc_fire  = alloc_valid && !rob_full;
    retire_fire = busy_q[head_q] && ready_q[head_q];
    mispredict  = retire_fire && (type_q[head_q] == T_BRANCH) &&
                  (value_q[head_q][0] != pred_q[head_q]);

    busy_d  = busy_q;
    ready_d = ready_q;
    pred_d  = pred_q;
    type_d  = type_q;
    rd_d    = rd_q;
    value_d = value_q;
    alt_d   = alt_q;
    for (int i = 1; i < 16; i++) begin
      // The tail slot is free when allocating, so a CDB hit on it is ignored by the busy test.
      if (alloc_fire && tail_q == 4'(i)) begin
        busy_d[i]  = 1'b1;
        ready_d[i] = (alloc_type == T_STORE);
        type_d[i]  = (alloc_type == 2'b11) ? T_REG : alloc_type;
        rd_d[i]    = alloc_rd;
        value_d[i] = 32'd0;
        pred_d[i]  = alloc_pred_taken;
        alt_d[i]   = alloc_alt_pc;
      end else if (busy_q[i] && cdb_alu_rob_id == 4'(i)) begin
        ready_d[i] = 1'b1;
        value_d[i] = cdb_alu_value;
      end else if (busy_q[i] && cdb_mem_rob_id == 4'(i)) begin
        ready_d[i] = 1'b1;
        value_d[i] = cdb_mem_value;
      end
      if ((retire_fire && head_q == 4'(i)) || mispredict) begin
        busy_d[i]  = 1'b0;
        ready_d[i] = 1'b0;
      end
    end

    head_d  = retire_fire ? ptr_inc(head_q) : head_q;
    tail_d  = alloc_fire ? ptr_inc(tail_q) : tail_q;
    count_d = count_q + 4'(alloc_fire) - 4'(retire_fire);
    if (mispredict) begin
      head_d  = 4'd1;
      tail_d  = 4'd1;
      count_d = 4'd0;
    end

    commit_valid_d = retire_fire;
    commit_id_d    = commit_id_q;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;
    commit_we_d    = 1'b0;
    commit_store_d = 1'b0;
    if (retire_fire) begin
      commit_id_d    = head_q;
      commit_rd_d    = rd_q[head_q];
      commit_value_d = value_q[head_q];
      commit_we_d    = (type_q[head_q] == T_REG) && (rd_q[head_q] != 5'd0);
      commit_store_d = (type_q[head_q] == T_STORE);
    end
    flush_d    = mispredict;
    flush_pc_d = mispredict ? alt_q[head_q] : flush_pc_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q  <= '0;
      ready_q <= '0;
      pred_q  <= '0;
      for (int i = 0; i < 16; i++) begin
        type_q[i]  <= T_REG;
        rd_q[i]    <= 5'd0;
        value_q[i] <= 32'd0;
        alt_q[i]   <= 32'd0;
      end
      head_q         <= 4'd1;
      tail_q         <= 4'd1;
      count_q        <= 4'd0;
      commit_valid_q <= 1'b0;
      commit_we_q    <= 1'b0;
      commit_store_q <= 1'b0;
      commit_id_q    <= 4'd0;
      commit_rd_q    <= 5'd0;
      commit_value_q <= 32'd0;
      flush_q        <= 1'b0;
      flush_pc_q     <= 32'd0;
    end else begin
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      pred_q         <= pred_d;
      type_q         <= type_d;
      rd_q           <= rd_d;
      value_q        <= value_d;
      alt_q          <= alt_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_we_q    <= commit_we_d;
      commit_store_q <= commit_store_d;
      commit_id_q    <= commit_id_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  assign commit_valid  = commit_valid_q;
  assign commit_rob_id = commit_id_q;
  assign commit_rd     = commit_rd_q;
  assign commit_we     = commit_we_q;
  assign commit_value  = commit_value_q;
  assign commit_store  = commit_store_q;
  assign flush_out     = flush_q;
  assign flush_pc      = flush_pc_q;

  // Returns {ready, value}; value is forced to 0 whenever ready is 0.
  function automatic logic [32:0] lookup(input logic [3:0] id);
    logic [32:0] r;
    r = 33'd0;
    if (id != 4'd0 && busy_q[id]) begin
      if (ready_q[id]) r = {1'b1, value_q[id]};
`ifdef ROB_CDB_BYPASS_EN
      if (cdb_alu_rob_id == id)      r = {1'b1, cdb_alu_value};
      else if (cdb_mem_rob_id == id) r = {1'b1, cdb_mem_value};
`endif
    end
    return r;
  endfunction

  always_comb begin
    {query_j_ready, query_j_value} = lookup(query_j_id);
    {query_k_ready, query_k_value} = lookup(query_k_id);
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (in-order retire, full/wrap, flush, store, query, reset).
module tb_reorder_buffer;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        alloc_valid;
  logic [1:0]  alloc_type;
  logic [4:0]  alloc_rd;
  logic        alloc_pred_taken;
  logic [31:0] alloc_alt_pc;
  logic [3:0]  alloc_id;
  logic        rob_full;
  logic [3:0]  cdb_alu_rob_id, cdb_mem_rob_id;
  logic [31:0] cdb_alu_value, cdb_mem_value;
  logic [3:0]  query_j_id, query_k_id;
  logic        query_j_ready, query_k_ready;
  logic [31:0] query_j_value, query_k_value;
  logic        commit_valid, commit_we, commit_store, flush_out;
  logic [3:0]  commit_rob_id;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, flush_pc;

  int n_cmp = 0;
  int n_bad = 0;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .alloc_valid(alloc_valid), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
    .alloc_pred_taken(alloc_pred_taken), .alloc_alt_pc(alloc_alt_pc),
    .alloc_id(alloc_id), .rob_full(rob_full),
    .cdb_alu_rob_id(cdb_alu_rob_id), .cdb_mem_rob_id(cdb_mem_rob_id),
    .cdb_alu_value(cdb_alu_value), .cdb_mem_value(cdb_mem_value),
    .query_j_id(query_j_id), .query_k_id(query_k_id),
    .query_j_ready(query_j_ready), .query_j_value(query_j_value),
    .query_k_ready(query_k_ready), .query_k_value(query_k_value),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .commit_rd(commit_rd),
    .commit_we(commit_we), .commit_value(commit_value), .commit_store(commit_store),
    .flush_out(flush_out), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; outputs are sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; alloc_type = 0; alloc_rd = 0; alloc_pred_taken = 0; alloc_alt_pc = 0;
    cdb_alu_rob_id = 0; cdb_alu_value = 0; cdb_mem_rob_id = 0; cdb_mem_value = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1; #3; rst_in = 0;
    tick();
  endtask

  task automatic alloc(input logic [1:0] t, input logic [4:0] rd, input logic p, input logic [31:0] alt);
    alloc_valid = 1; alloc_type = t; alloc_rd = rd; alloc_pred_taken = p; alloc_alt_pc = alt;
    tick();
    alloc_valid = 0;
  endtask

  task automatic wb_alu(input logic [3:0] id, input logic [31:0] v);
    cdb_alu_rob_id = id; cdb_alu_value = v;
    tick();
    cdb_alu_rob_id = 0; cdb_alu_value = 0;
  endtask

  initial begin
    query_j_id = 0; query_k_id = 0;
    do_reset();
    check("rst_alloc_id", 32'(alloc_id), 1);
    check("rst_full", 32'(rob_full), 0);
    check("rst_cvalid", 32'(commit_valid), 0);
    check("rst_flush", 32'(flush_out), 0);
    check("rst_flush_pc", flush_pc, 0);

    // In-order retire of out-of-order writebacks
    for (int i = 0; i < 3; i++) alloc(2'b00, 5'(5 + i), 0, 0);
    check("t1_alloc_id", 32'(alloc_id), 4);
    wb_alu(2, 32'h22);
    query_j_id = 2; #1;
    check("t1_q2_ready", 32'(query_j_ready), 1);
    check("t1_q2_value", query_j_value, 32'h22);
    check("t1_no_commit", 32'(commit_valid), 0);
    wb_alu(1, 32'h11);
    check("t1_no_commit2", 32'(commit_valid), 0);
    wb_alu(3, 32'h33);
    check("t1_c1_valid", 32'(commit_valid), 1);
    check("t1_c1_id", 32'(commit_rob_id), 1);
    check("t1_c1_value", commit_value, 32'h11);
    check("t1_c1_rd", 32'(commit_rd), 5);
    check("t1_c1_we", 32'(commit_we), 1);
    tick();
    check("t1_c2_id", 32'(commit_rob_id), 2);
    check("t1_c2_value", commit_value, 32'h22);
    check("t1_c2_we", 32'(commit_we), 1);
    tick();
    check("t1_c3_id", 32'(commit_rob_id), 3);
    check("t1_c3_value", commit_value, 32'h33);
    tick();
    check("t1_idle", 32'(commit_valid), 0);

    // Fill, reject on full, wrap
    do_reset();
    for (int i = 1; i <= 15; i++) alloc(2'b00, 5'(i), 0, 0);
    check("t2_full", 32'(rob_full), 1);
    check("t2_full_id", 32'(alloc_id), 1);
    alloc(2'b00, 5'd20, 0, 0);
    check("t2_drop_full", 32'(rob_full), 1);
    check("t2_drop_id", 32'(alloc_id), 1);
    wb_alu(1, 32'h1);
    alloc_valid = 1; alloc_type = 0; alloc_rd = 5'd21;
    tick();
    check("t2_ret_valid", 32'(commit_valid), 1);
    check("t2_ret_id", 32'(commit_rob_id), 1);
    check("t2_rej_id", 32'(alloc_id), 1);
    check("t2_not_full", 32'(rob_full), 0);
    tick();
    alloc_valid = 0;
    check("t2_wrap_id", 32'(alloc_id), 2);
    check("t2_refull", 32'(rob_full), 1);

    // Mispredicted branch flush
    do_reset();
    alloc(2'b10, 0, 0, 0);
    alloc(2'b10, 0, 0, 0);
    check("t3_store_valid", 32'(commit_valid), 1);
    check("t3_store_flag", 32'(commit_store), 1);
    check("t3_store_id", 32'(commit_rob_id), 1);
    check("t3_store_we", 32'(commit_we), 0);
    alloc(2'b10, 0, 0, 0);
    alloc(2'b01, 0, 0, 32'h1000);
    alloc(2'b00, 5'd8, 0, 0);
    alloc(2'b00, 5'd9, 0, 0);
    wb_alu(4, 32'h1);
    check("t3_pre_flush", 32'(flush_out), 0);
    tick();
    check("t3_br_valid", 32'(commit_valid), 1);
    check("t3_br_id", 32'(commit_rob_id), 4);
    check("t3_br_we", 32'(commit_we), 0);
    check("t3_flush", 32'(flush_out), 1);
    check("t3_flush_pc", flush_pc, 32'h1000);
    check("t3_alloc_id", 32'(alloc_id), 1);
    cdb_alu_rob_id = 5; cdb_alu_value = 32'h55;
    tick();
    cdb_alu_rob_id = 0;
    check("t3_flush_gone", 32'(flush_out), 0);
    check("t3_post_cvalid", 32'(commit_valid), 0);
    query_j_id = 5; #1;
    check("t3_q5_cleared", 32'(query_j_ready), 0);

    // Correctly predicted branch
    alloc(2'b01, 0, 1, 32'h2000);
    wb_alu(1, 32'h1);
    tick();
    check("t4_valid", 32'(commit_valid), 1);
    check("t4_we", 32'(commit_we), 0);
    check("t4_flush", 32'(flush_out), 0);

    // Store at empty head; writebacks to ID 0 and a free ID are ignored
    cdb_alu_rob_id = 0; cdb_alu_value = 32'hDEAD;
    cdb_mem_rob_id = 9; cdb_mem_value = 32'hBEEF;
    alloc(2'b10, 5'd3, 0, 0);
    cdb_alu_value = 0; cdb_mem_rob_id = 0; cdb_mem_value = 0;
    check("t5_alloc_id", 32'(alloc_id), 3);
    tick();
    check("t5_valid", 32'(commit_valid), 1);
    check("t5_store", 32'(commit_store), 1);
    check("t5_id", 32'(commit_rob_id), 2);
    check("t5_value", commit_value, 0);
    query_k_id = 9; #1;
    check("t5_q9", 32'(query_k_ready), 0);

    // Query with same-cycle CDB, ALU precedence, async reset
    do_reset();
    alloc(2'b00, 5'd1, 0, 0);
    alloc(2'b00, 5'd2, 0, 0);
    query_j_id = 2; cdb_alu_rob_id = 2; cdb_alu_value = 32'hAB; #1;
`ifdef ROB_CDB_BYPASS_EN
    check("t6_byp_ready", 32'(query_j_ready), 1);
    check("t6_byp_value", query_j_value, 32'hAB);
`else
    check("t6_byp_ready", 32'(query_j_ready), 0);
    check("t6_byp_value", query_j_value, 0);
`endif
    tick();
    cdb_alu_rob_id = 0;
    #1;
    check("t6_q_ready", 32'(query_j_ready), 1);
    check("t6_q_value", query_j_value, 32'hAB);
    cdb_alu_rob_id = 1; cdb_alu_value = 32'h111;
    cdb_mem_rob_id = 1; cdb_mem_value = 32'h222;
    tick();
    idle_inputs();
    query_k_id = 1; #1;
    check("t6_alu_wins", query_k_value, 32'h111);
    tick();
    check("t6_pre_rst_cvalid", 32'(commit_valid), 1);
    rst_in = 1; #1;
    check("t6_rst_cvalid", 32'(commit_valid), 0);
    check("t6_rst_cid", 32'(commit_rob_id), 0);
    check("t6_rst_cvalue", commit_value, 0);
    check("t6_rst_cwe", 32'(commit_we), 0);
    check("t6_rst_alloc_id", 32'(alloc_id), 1);
    check("t6_rst_qj", 32'(query_j_ready), 0);
    rst_in = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
